// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one asynchronous RAM between the CPU and loader ports and generates its strobes
// Ports: cpu_*/ld_* level requests held until a one-cycle *_ack, with read data in *_rdata;
//        ram_* drive the RAM chip enable, output and write strobes, address and write data, and ram_din returns read data;
//        busy is high outside IDLE, and owner shows the port of the current or last grant (0 = CPU, 1 = loader).
module ram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CPU_BURST = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [11:0] cpu_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [12:0] ld_addr,
  input  logic [11:0] ld_wdata,
  output logic        ld_ack,
  output logic [11:0] ld_rdata,
  output logic        ram_nce,
  output logic        ram_noe,
  output logic        ram_nwe,
  output logic [12:0] ram_abus,
  output logic [11:0] ram_dout,
  output logic        ram_dout_en,
  input  logic [11:0] ram_din,
  output logic        busy,
  output logic        owner
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] BURST = 4'(CPU_BURST);
  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d, streak_q, streak_d;
  logic owner_q, owner_d, we_q, we_d, pick_ld;
  logic [12:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
  logic nce_q, noe_q, nwe_q, dout_en_q, cpu_ack_q, ld_ack_q, busy_q;
  always_comb begin
    pick_ld = ld_req && (!cpu_req || streak_q == BURST);
    state_d = state_q;
    wcnt_d = wcnt_q;
    streak_d = streak_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d = ld_rdata_q;
    case (state_q)
      IDLE: if (cpu_req || ld_req) begin
        state_d = SETUP;
        owner_d = pick_ld;
        we_d = pick_ld ? ld_we : cpu_we;
        addr_d = pick_ld ? ld_addr : cpu_addr;
        wdata_d = pick_ld ? ld_wdata : cpu_wdata;
        streak_d = (pick_ld || !ld_req) ? 4'd0 : streak_q + {3'd0, streak_q != BURST};
      end
      SETUP: begin
        state_d = STROBE;
        wcnt_d = WLAST;
      end
      STROBE: begin
        state_d = (wcnt_q == 4'd0) ? RECOVER : STROBE;
        wcnt_d = wcnt_q - 4'd1;
        // read data is taken while OE is still asserted, into the owner's register only
        if (wcnt_q == 4'd0 && !we_q) begin
          cpu_rdata_d = owner_q ? cpu_rdata_q : ram_din;
          ld_rdata_d = owner_q ? ram_din : ld_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // strobes are registered from the next state so every output comes straight from a flop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      streak_q <= '0;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q <= '0;
      nce_q <= 1'b1;
      noe_q <= 1'b1;
      nwe_q <= 1'b1;
      dout_en_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ld_ack_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      streak_q <= streak_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q <= ld_rdata_d;
      nce_q <= state_d == IDLE;
      noe_q <= !(state_d == STROBE && !we_d);
      nwe_q <= !(state_d == STROBE && we_d);
      dout_en_q <= state_d != IDLE && we_d;
      cpu_ack_q <= state_d == RECOVER && !owner_d;
      ld_ack_q <= state_d == RECOVER && owner_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign cpu_ack = cpu_ack_q;
  assign ld_ack = ld_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata = ld_rdata_q;
  assign ram_nce = nce_q;
  assign ram_noe = noe_q;
  assign ram_nwe = nwe_q;
  assign ram_abus = addr_q;
  assign ram_dout = wdata_q;
  assign ram_dout_en = dout_en_q;
  assign busy = busy_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: checks two arbiter instances (W=1 and W=3) against a cycle-count reference model
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  logic cpu_req[2], cpu_we[2], ld_req[2], ld_we[2];
  logic [12:0] cpu_addr[2], ld_addr[2], ram_abus[2];
  logic [11:0] cpu_wdata[2], ld_wdata[2], cpu_rdata[2], ld_rdata[2], ram_dout[2], ram_din[2];
  logic cpu_ack[2], ld_ack[2], ram_nce[2], ram_noe[2], ram_nwe[2], ram_dout_en[2], busy[2], owner[2];
  int noe_cnt[2], nwe_cnt[2];
  bit ord[$];
  logic [12:0] addrs[8] = '{13'h1A5, 13'h0800, 13'h0000, 13'h0001, 13'h0FFF, 13'h1000, 13'h1FFF, 13'h0555};
  typedef struct {
    bit p;
    bit we;
    logic [12:0] a;
    logic [11:0] wd;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, g, cyc, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 1) ? 3 : 1;
    ram_arbiter #(.WAIT_CYCLES(W), .CPU_BURST(4)) dut (
      .clk(clk), .nrst(nrst),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_wdata(ld_wdata[g]),
      .ld_ack(ld_ack[g]), .ld_rdata(ld_rdata[g]),
      .ram_nce(ram_nce[g]), .ram_noe(ram_noe[g]), .ram_nwe(ram_nwe[g]), .ram_abus(ram_abus[g]),
      .ram_dout(ram_dout[g]), .ram_dout_en(ram_dout_en[g]), .ram_din(ram_din[g]),
      .busy(busy[g]), .owner(owner[g])
    );
    logic [11:0] mem [8192];
    always @(posedge clk) if (!ram_nce[g] && !ram_nwe[g]) mem[ram_abus[g]] <= ram_dout[g];
    assign ram_din[g] = mem[ram_abus[g]];
    int next_idle = 0, gcyc = -100, streak = 0, k;
    bit gport = 1'b0, gwe = 1'b0, bsy, stb, ack;
    logic [12:0] gaddr = '0;
    logic [11:0] gwd = '0, erc = '0, erl = '0, prd = '0;
    logic [11:0] shadow [8192];
    always @(negedge clk) begin
      if (!nrst) begin
        next_idle = cyc;
        gcyc = -100;
        streak = 0;
        gport = 1'b0;
        gwe = 1'b0;
        gaddr = '0;
        gwd = '0;
        erc = '0;
        erl = '0;
      end else if (cyc == gcyc + 2 + W && !gwe) begin
        if (gport) erl = prd;
        else erc = prd;
      end
      k = cyc - gcyc;
      bsy = k >= 1 && k <= 2 + W;
      stb = k >= 2 && k <= 1 + W;
      ack = k == 2 + W;
      chk("ram_nce", g, 32'(ram_nce[g]), 32'(!bsy));
      chk("ram_noe", g, 32'(ram_noe[g]), 32'(!(stb && !gwe)));
      chk("ram_nwe", g, 32'(ram_nwe[g]), 32'(!(stb && gwe)));
      chk("ram_dout_en", g, 32'(ram_dout_en[g]), 32'(bsy && gwe));
      chk("ram_abus", g, 32'(ram_abus[g]), 32'(gaddr));
      if (bsy && gwe) chk("ram_dout", g, 32'(ram_dout[g]), 32'(gwd));
      chk("busy", g, 32'(busy[g]), 32'(bsy));
      chk("owner", g, 32'(owner[g]), 32'(gport));
      chk("cpu_ack", g, 32'(cpu_ack[g]), 32'(ack && !gport));
      chk("ld_ack", g, 32'(ld_ack[g]), 32'(ack && gport));
      chk("cpu_rdata", g, 32'(cpu_rdata[g]), 32'(erc));
      chk("ld_rdata", g, 32'(ld_rdata[g]), 32'(erl));
      chk("both_ack", g, 32'(cpu_ack[g] && ld_ack[g]), 32'(0));
      if (nrst && cyc >= next_idle && (cpu_req[g] || ld_req[g])) begin
        gport = ld_req[g] && (!cpu_req[g] || streak == 4);
        streak = (gport || !ld_req[g]) ? 0 : (streak < 4 ? streak + 1 : 4);
        gwe = gport ? ld_we[g] : cpu_we[g];
        gaddr = gport ? ld_addr[g] : cpu_addr[g];
        gwd = gport ? ld_wdata[g] : cpu_wdata[g];
        if (gwe) shadow[gaddr] = gwd;
        else prd = shadow[gaddr];
        gcyc = cyc;
        next_idle = cyc + 3 + W;
      end
      if (!ram_noe[g]) noe_cnt[g]++;
      if (!ram_nwe[g]) nwe_cnt[g]++;
    end
  end
  task automatic set_req(input int i, input bit p, input bit r, input bit we, input logic [12:0] a, input logic [11:0] d);
    if (p) begin
      ld_req[i] = r;
      ld_we[i] = we;
      ld_addr[i] = a;
      ld_wdata[i] = d;
    end else begin
      cpu_req[i] = r;
      cpu_we[i] = we;
      cpu_addr[i] = a;
      cpu_wdata[i] = d;
    end
  endtask
  task automatic do_access(input int i, input bit p, input bit we, input logic [12:0] a, input logic [11:0] d,
                           input bit mut, output logic [11:0] rd, output int ackc, output int lat);
    int s;
    bit m;
    m = mut;
    ackc = -1;
    set_req(i, p, 1'b1, we, a, d);
    s = cyc;
    for (int t = 0; t < 40 && ackc < 0; t++) begin
      @(posedge clk);
      #1;
      if (m && (!ram_noe[i] || !ram_nwe[i])) begin
        set_req(i, p, 1'b1, we, a ^ 13'h0F0F, ~d);
        m = 1'b0;
      end
      if (p ? ld_ack[i] : cpu_ack[i]) ackc = cyc;
    end
    if (ackc < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d port %0d: got no ack, want ack within 40 cycles", i, p);
    end else if (i == 0) ord.push_back(p);
    rd = p ? ld_rdata[i] : cpu_rdata[i];
    lat = ackc - s;
    set_req(i, p, 1'b0, we, a, d);
  endtask
  task automatic rand_port(input int i, input bit p);
    logic [11:0] rd;
    int ac, lat;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      do_access(i, p, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], 12'($urandom), 1'b0, rd, ac, lat);
      chk("rand_lat_min", i, 32'(lat >= ((i == 1) ? 5 : 3)), 32'(1));
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before 1000000 time units");
    $fatal(1);
  end
  initial begin
    logic [11:0] rd;
    int ac, lat, n0, w0;
    int acs[4];
    bit seen;
    bit fexp[10];
    fexp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[0]  = '{0, 1, 13'h01A5, 12'h3C7, 12'h000};
    tbl[1]  = '{1, 1, 13'h0800, 12'hABC, 12'h000};
    tbl[2]  = '{0, 1, 13'h0000, 12'h001, 12'h000};
    tbl[3]  = '{1, 1, 13'h0001, 12'h002, 12'h000};
    tbl[4]  = '{0, 1, 13'h0FFF, 12'hFFF, 12'h000};
    tbl[5]  = '{1, 1, 13'h1000, 12'h800, 12'h000};
    tbl[6]  = '{0, 1, 13'h1FFF, 12'h555, 12'h000};
    tbl[7]  = '{1, 1, 13'h0555, 12'h7E1, 12'h000};
    tbl[8]  = '{0, 0, 13'h01A5, 12'h000, 12'h3C7};
    tbl[9]  = '{0, 0, 13'h0800, 12'h000, 12'hABC};
    tbl[10] = '{1, 0, 13'h1FFF, 12'h000, 12'h555};
    tbl[11] = '{1, 0, 13'h0000, 12'h000, 12'h001};
    tbl[12] = '{0, 0, 13'h1000, 12'h000, 12'h800};
    tbl[13] = '{0, 0, 13'h0FFF, 12'h000, 12'hFFF};
    tbl[14] = '{1, 0, 13'h0001, 12'h000, 12'h002};
    tbl[15] = '{0, 0, 13'h0555, 12'h000, 12'h7E1};
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(i, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    fork
      for (int n = 0; n < 8; n++) do_access(0, 1'b0, 1'b1, 13'h0100 + 13'(n), 12'(n), 1'b0, rd, ac, lat);
      for (int n = 0; n < 2; n++) do_access(0, 1'b1, 1'b1, 13'h0200 + 13'(n), 12'(n), 1'b0, rd, ac, lat);
    join
    chk("fair_count", 0, 32'(ord.size()), 32'(10));
    for (int n = 0; n < 10; n++) chk("fair_order", 0, 32'(ord[n]), 32'(fexp[n]));
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 16; n++) begin
        @(posedge clk);
        #1;
        do_access(i, tbl[n].p, tbl[n].we, tbl[n].a, tbl[n].wd, 1'b0, rd, ac, lat);
        chk("tbl_latency", i, 32'(lat), 32'((i == 1) ? 5 : 3));
        if (!tbl[n].we) chk("tbl_rdata", i, 32'(rd), 32'(tbl[n].exp));
      end
    @(posedge clk);
    #1;
    do_access(0, 1'b0, 1'b0, 13'h0800, 12'h000, 1'b1, rd, ac, lat);
    chk("latch_read", 0, 32'(rd), 32'(12'hABC));
    @(posedge clk);
    #1;
    do_access(0, 1'b0, 1'b1, 13'h0555, 12'h111, 1'b1, rd, ac, lat);
    @(posedge clk);
    #1;
    do_access(0, 1'b0, 1'b0, 13'h0555, 12'h000, 1'b0, rd, ac, lat);
    chk("latch_write", 0, 32'(rd), 32'(12'h111));
    n0 = noe_cnt[1];
    w0 = nwe_cnt[1];
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) do_access(1, 1'b0, 1'b0, 13'h01A5, 12'h000, 1'b0, rd, acs[n], lat);
    for (int n = 1; n < 4; n++) chk("w3_ack_period", 1, 32'(acs[n] - acs[n-1]), 32'(6));
    chk("w3_noe_cycles", 1, 32'(noe_cnt[1] - n0), 32'(12));
    chk("w3_nwe_cycles", 1, 32'(nwe_cnt[1] - w0), 32'(0));
    chk("w3_rdata", 1, 32'(rd), 32'(12'h3C7));
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b1, 1'b1, 13'h0123, 12'h5A5);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = !ram_nwe[0];
    end
    chk("rst_strobe_seen", 0, 32'(seen), 32'(1));
    #2 nrst = 1'b0;
    #1;
    chk("rst_nwe", 0, 32'(ram_nwe[0]), 32'(1));
    chk("rst_nce", 0, 32'(ram_nce[0]), 32'(1));
    chk("rst_noe", 0, 32'(ram_noe[0]), 32'(1));
    chk("rst_dout_en", 0, 32'(ram_dout_en[0]), 32'(0));
    chk("rst_abus", 0, 32'(ram_abus[0]), 32'(0));
    chk("rst_dout", 0, 32'(ram_dout[0]), 32'(0));
    chk("rst_busy", 0, 32'(busy[0]), 32'(0));
    chk("rst_owner", 0, 32'(owner[0]), 32'(0));
    chk("rst_acks", 0, 32'({cpu_ack[0], ld_ack[0]}), 32'(0));
    chk("rst_rdata", 0, 32'({cpu_rdata[0], ld_rdata[0]}), 32'(0));
    set_req(0, 1'b0, 1'b1, 1'b0, 13'h01A5, 12'h000);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    do_access(0, 1'b0, 1'b0, 13'h01A5, 12'h000, 1'b0, rd, ac, lat);
    chk("post_rst_latency", 0, 32'(lat), 32'(3));
    chk("post_rst_rdata", 0, 32'(rd), 32'(12'h3C7));
    fork
      rand_port(0, 1'b0);
      rand_port(0, 1'b1);
      rand_port(1, 1'b0);
      rand_port(1, 1'b1);
    join
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single asynchronous RAM between two requesters: the CPU datapath (port `cpu_*`) and the front-panel/serial loader (port `ld_*`). It generates the RAM chip-select, output-enable and write-enable strobes with a programmable strobe width. It also latches the address and data, and returns read data with a one-cycle acknowledge. It sits between the control/slice datapath and the `ram` instance, replacing direct drive of `ram_nce`/`ram_noe`/`nwrm`.

## Interface
- `WAIT_CYCLES`, default 1: width of the OE/WE strobe in clocks; legal range 1..15.
- `CPU_BURST`, default 4: maximum consecutive CPU grants while `ld_req` is pending; legal range 1..15.

- `clk`  in  1  system clock. One clock; all state changes on its rising edge.
- `nrst`  in  1  reset. Asynchronous, active-low.
- `cpu_req`  in  1  CPU access request. Level; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  13  word address (bit 12 = field).
- `cpu_wdata`  in  12  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  12  last CPU read data; valid from the `cpu_ack` cycle and held until the next CPU read completes.
- `ld_req`, `ld_we`, `ld_addr[12:0]`, `ld_wdata[11:0]`, `ld_ack`, `ld_rdata[11:0]`: loader port, identical semantics to the CPU port.
- `ram_nce`  out  1  RAM chip enable, active-low.
- `ram_noe`  out  1  RAM output enable, active-low.
- `ram_nwe`  out  1  RAM write enable, active-low.
- `ram_abus`  out  13  RAM address.
- `ram_dout`  out  12  write data to RAM.
- `ram_dout_en`  out  1  1 = drive `ram_dout` onto the data bus.
- `ram_din`  in  12  RAM read data.
- `busy`  out  1  1 in any state other than IDLE.
- `owner`  out  1  port of the current or last grant: 0 = CPU, 1 = loader.

## Operation
- The FSM has four states: IDLE, SETUP, STROBE, RECOVER. A 4-bit counter `wcnt` tracks the STROBE length.
- **IDLE:** requests are sampled only in this state.
  - Only one `*_req` high: grant that port.
  - Both high: grant the CPU unless `streak == CPU_BURST`, in which case grant the loader.
  - On grant, latch `we`, `addr` and `wdata` from the granted port, set `owner`, and go to SETUP.
  - Request inputs are ignored after the grant until the next IDLE.
- **Streak counter:**
  - On a CPU grant with `ld_req` = 1, `streak` increments, saturating at `CPU_BURST`.
  - On a CPU grant with `ld_req` = 0, `streak` clears to 0.
  - On any loader grant, `streak` clears to 0.
- **SETUP (1 cycle):**
  - `ram_abus` = latched addr, `ram_nce` = 0; `ram_noe` and `ram_nwe` = 1.
  - For writes, `ram_dout` = latched data and `ram_dout_en` = 1.
- **STROBE (WAIT_CYCLES cycles):**
  - Read: `ram_noe` = 0.
  - Write: `ram_nwe` = 0.
  - At the edge ending the final STROBE cycle, a read captures `ram_din` into the owner's rdata register only.
- **RECOVER (1 cycle):**
  - Strobes high; `ram_nce`, `ram_abus`, `ram_dout` and `ram_dout_en` held.
  - The owner's `*_ack` = 1. Then go to IDLE.
- **Outputs in IDLE:** `ram_nce` = 1, `ram_dout_en` = 0; `ram_abus`/`ram_dout` hold their last values.
- **Invariants:**
  - `ram_noe` and `ram_nwe` are never both 0.
  - `ram_nwe` = 0 implies `ram_dout_en` = 1.
  - `ram_dout_en` is never 1 for a read.
  - Both acks are never 1 together.
- **Requester handshake:** a requester must drop `req`, or present a new request, by the edge ending the ack cycle. A `req` still high in IDLE is a new access.
- **Reset (`nrst` = 0):**
  - FSM to IDLE immediately.
  - `ram_nce`/`ram_noe`/`ram_nwe` = 1; `ram_abus`, `ram_dout`, `cpu_rdata` and `ld_rdata` = 0; `ram_dout_en` = 0.
  - Acks = 0, `busy` = 0, `owner` = 0, `streak` = 0.
  - Reset mid-access aborts the access with no ack. The write target word is undefined.

## Timing
- Request sampled high at edge 0 in IDLE: SETUP is cycle 1, STROBE is cycles 2..1+W, the ack is in cycle 2+W, and IDLE is cycle 3+W.
- A new grant is sampled at the edge ending cycle 3+W. Back-to-back throughput is one access per 3+W cycles.
- Setup margin: address and chip enable are stable 1 cycle before the strobe and 1 cycle after it.
- `busy` is high in cycles 1..2+W.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- **CPU read:** W=1, RAM[0x1A5] = 0x3C7, `cpu_req` at edge 0 with addr 0x1A5 → `ram_noe` low in cycle 2 only, `cpu_ack` in cycle 3, `cpu_rdata` = 0x3C7, `ld_rdata` unchanged.
- **Loader write then CPU read:** loader writes 0xABC to 0x0800 → `ram_nwe` low exactly W cycles, `ram_dout_en` high in cycles 1..2+W, `ld_ack` once. A following CPU read of 0x0800 returns 0xABC.
- **Fairness:** `CPU_BURST` = 4, both requests held continuously, each re-presented after its ack → grant order C,C,C,C,L,C,C,C,C,L. No cycle has both acks high.
- **Latching:** change `cpu_addr`/`cpu_wdata` during STROBE → the RAM sees the values latched at grant; the new values are ignored until the next IDLE.
- **Reset mid-write:** drop `nrst` during STROBE of a write → `ram_nwe` and `ram_nce` go high without waiting for a clock, no ack, all outputs at their reset values. After release, a CPU read completes with normal latency.
- **Strobe width:** W=3, continuous CPU reads → `cpu_ack` every 6 cycles, `ram_noe` low 3 cycles per access, `ram_nwe` constantly 1.
